// File: rtl/sprite_pixel_pipe_pkg.sv
// Shared constants and helpers for the sprite pixel pipeline.
// Also holds the movement and animation-frame codes used by the game logic.
package sprite_pixel_pipe_pkg;

    localparam int          SPRITE_SIZE = 16;
    localparam int          SCALE_LOG   = 1;
    localparam int          SPRITE_LEN  = SPRITE_SIZE << SCALE_LOG;
    localparam int          FRAME_BITS  = 2;
    localparam logic [11:0] TRANSPARENT = 12'hCBE;
    localparam logic [11:0] BG_COLOR    = 12'hFFF;

    typedef enum logic [2:0] {
        MOVE_NONE  = 3'd0,
        MOVE_UP    = 3'd1,
        MOVE_DOWN  = 3'd2,
        MOVE_LEFT  = 3'd3,
        MOVE_RIGHT = 3'd4
    } move_e;

    typedef enum logic [FRAME_BITS-1:0] {
        FRAME_IDLE  = 2'd0,
        FRAME_WALK0 = 2'd1,
        FRAME_WALK1 = 2'd2,
        FRAME_JUMP  = 2'd3
    } frame_sel_e;

    // Final pixel colour: blanking wins, then sprite miss, then the colour key.
    function automatic logic [11:0] resolve_color(
        input logic        valid,
        input logic        hit,
        input logic [11:0] texel,
        input logic [11:0] key,
        input logic [11:0] bg
    );
        if (!valid)            return 12'h000;
        else if (!hit)         return bg;
        else if (texel == key) return bg;
        else                   return texel;
    endfunction

endpackage

// File: rtl/sprite_pixel_pipe_delay.sv
// Fixed-depth shift-register delay line with a synchronous reset value.
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_taps [DEPTH];

    // NOTE: every tap is reset on purpose; these carry sync/valid flags, so stale
    // contents after reset would leak out as bogus pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_taps[i] <= RESET_VAL;
        end else begin
            r_taps[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_taps[i] <= r_taps[i-1];
        end
    end

    assign o_q = r_taps[DEPTH-1];

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Three-stage pixel pipeline: sprite hit test and ROM addressing, ROM read,
// then colour resolve, with sync delayed to stay aligned with colour.
module sprite_pixel_pipe #(
    parameter int          SPRITE_SIZE = sprite_pixel_pipe_pkg::SPRITE_SIZE,
    parameter int          SCALE_LOG   = sprite_pixel_pipe_pkg::SCALE_LOG,
    parameter int          FRAME_BITS  = sprite_pixel_pipe_pkg::FRAME_BITS,
    parameter logic [11:0] TRANSPARENT = sprite_pixel_pipe_pkg::TRANSPARENT,
    parameter logic [11:0] BG_COLOR    = sprite_pixel_pipe_pkg::BG_COLOR
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          valid_in,
    input  logic [9:0]                                    h_cnt,
    input  logic [9:0]                                    v_cnt,
    input  logic                                          hsync_in,
    input  logic                                          vsync_in,
    input  logic                                          sprite_en,
    input  logic [9:0]                                    sprite_r,
    input  logic [9:0]                                    sprite_c,
    input  logic [FRAME_BITS-1:0]                         frame_sel,
    output logic [FRAME_BITS+2*$clog2(SPRITE_SIZE)-1:0]   rom_addr,
    input  logic [11:0]                                   rom_data,
    output logic                                          hsync,
    output logic                                          vsync,
    output logic [11:0]                                   color
);
    import sprite_pixel_pipe_pkg::*;

    localparam int          TEX_BITS = $clog2(SPRITE_SIZE);
    localparam logic [10:0] LEN      = 11'(SPRITE_SIZE << SCALE_LOG);

    logic                  r_vsync_prev;
    logic                  r_en_sh;
    logic [9:0]            r_row_sh;
    logic [9:0]            r_col_sh;
    logic [FRAME_BITS-1:0] r_frame_sh;

    logic                  w_frame_start;
    logic [10:0]           w_dv;
    logic [10:0]           w_dh;
    logic                  w_hit;
    logic [TEX_BITS-1:0]   w_tex_row;
    logic [TEX_BITS-1:0]   w_tex_col;
    logic [1:0]            w_hit_valid_d2;
    logic [1:0]            w_sync_d3;

    assign w_frame_start = r_vsync_prev & ~vsync_in;

    // Sprite parameters are only sampled at frame start so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_prev <= 1'b1;
            r_en_sh      <= 1'b0;
            r_row_sh     <= '0;
            r_col_sh     <= '0;
            r_frame_sh   <= '0;
        end else begin
            r_vsync_prev <= vsync_in;
            if (w_frame_start) begin
                r_en_sh    <= sprite_en;
                r_row_sh   <= sprite_r;
                r_col_sh   <= sprite_c;
                r_frame_sh <= frame_sel;
            end
        end
    end

    // Offsets are one bit wider so a raster position left/above the sprite shows up as negative.
    assign w_dv      = {1'b0, v_cnt} - {1'b0, r_row_sh};
    assign w_dh      = {1'b0, h_cnt} - {1'b0, r_col_sh};
    assign w_hit     = r_en_sh & valid_in & ~w_dv[10] & ~w_dh[10] & (w_dv < LEN) & (w_dh < LEN);
    assign w_tex_row = TEX_BITS'(w_dv >> SCALE_LOG);
    assign w_tex_col = TEX_BITS'(w_dh >> SCALE_LOG);

    always_ff @(posedge clk) begin
        if (rst) rom_addr <= '0;
        else     rom_addr <= w_hit ? {r_frame_sh, w_tex_row, w_tex_col} : '0;
    end

    pipe_delay #(
        .WIDTH     (2),
        .DEPTH     (2),
        .RESET_VAL (2'b00)
    ) u_hit_valid_delay (
        .clk (clk),
        .rst (rst),
        .i_d ({w_hit, valid_in}),
        .o_q (w_hit_valid_d2)
    );

    pipe_delay #(
        .WIDTH     (2),
        .DEPTH     (3),
        .RESET_VAL (2'b11)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .i_d ({hsync_in, vsync_in}),
        .o_q (w_sync_d3)
    );

    assign hsync = w_sync_d3[1];
    assign vsync = w_sync_d3[0];

    always_ff @(posedge clk) begin
        if (rst) color <= '0;
        else     color <= resolve_color(w_hit_valid_d2[0], w_hit_valid_d2[1], rom_data,
                                        TRANSPARENT, BG_COLOR);
    end

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Self-checking bench for sprite_pixel_pipe: directed scenarios plus random
// raster traffic, compared against a behavioural model of the sprite overlay.
module tb_sprite_pixel_pipe;

    localparam logic [11:0] KEY = 12'hCBE;
    localparam logic [11:0] BG  = 12'hFFF;
    localparam int          LEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        hsync_in;
    logic        vsync_in;
    logic        sprite_en;
    logic [9:0]  sprite_r;
    logic [9:0]  sprite_c;
    logic [1:0]  frame_sel;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data;
    logic        hsync;
    logic        vsync;
    logic [11:0] color;

    sprite_pixel_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .sprite_en (sprite_en),
        .sprite_r  (sprite_r),
        .sprite_c  (sprite_c),
        .frame_sel (frame_sel),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .hsync     (hsync),
        .vsync     (vsync),
        .color     (color)
    );

    always #20 clk = ~clk;

    logic [11:0] rom_mem [1024];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct {
        logic [11:0] color;
        logic        hs;
        logic        vs;
    } out_t;

    out_t        m_pipe [3];
    int          m_prev_vs;
    int          m_en;
    int          m_r;
    int          m_c;
    int          m_frame;
    logic [9:0]  m_addr;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive the raster, advance the model, check all outputs.
    task automatic cyc(input string tag, input int v, input int h, input bit valid,
                       input bit hs, input bit vs);
        out_t        e;
        bit          hit;
        int          a;
        logic [11:0] word;
        v_cnt    = 10'(v);
        h_cnt    = 10'(h);
        valid_in = valid;
        hsync_in = hs;
        vsync_in = vs;
        hit  = (m_en != 0) && valid && v >= m_r && v < m_r + LEN && h >= m_c && h < m_c + LEN;
        a    = hit ? m_frame * 256 + ((v - m_r) / 2) * 16 + (h - m_c) / 2 : 0;
        word = rom_mem[a];
        e.hs = hs;
        e.vs = vs;
        if (!valid)           e.color = 12'h000;
        else if (!hit)        e.color = BG;
        else if (word == KEY) e.color = BG;
        else                  e.color = word;
        if (rst) begin
            for (int i = 0; i < 3; i++) m_pipe[i] = '{12'h000, 1'b1, 1'b1};
            m_addr    = '0;
            m_prev_vs = 1;
            m_en      = 0;
            m_r       = 0;
            m_c       = 0;
            m_frame   = 0;
        end else begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = e;
            m_addr    = 10'(a);
            if (m_prev_vs != 0 && !vs) begin
                m_en    = sprite_en;
                m_r     = sprite_r;
                m_c     = sprite_c;
                m_frame = frame_sel;
            end
            m_prev_vs = vs;
        end
        @(posedge clk);
        #1;
        check({tag, "/color"}, color, m_pipe[2].color);
        check({tag, "/hsync"}, 12'(hsync), 12'(m_pipe[2].hs));
        check({tag, "/vsync"}, 12'(vsync), 12'(m_pipe[2].vs));
        check({tag, "/rom_addr"}, 12'(rom_addr), 12'(m_addr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc("idle", 0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic vsync_pulse();
        cyc("vs_lo", 0, 0, 1'b0, 1'b1, 1'b0);
        cyc("vs_lo", 0, 0, 1'b0, 1'b1, 1'b0);
        cyc("vs_hi", 0, 0, 1'b0, 1'b1, 1'b1);
        cyc("vs_hi", 0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic scan(input string tag, input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) cyc(tag, v, h, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        int    rows_hit [5];
        int    v;
        int    h;
        bit    vs;
        int    vs_left;
        bit    just_reset;
        rows_hit = '{299, 300, 315, 331, 332};
        for (int i = 0; i < 1024; i++) rom_mem[i] = 12'h0F0;
        sprite_en = 1'b0;
        sprite_r  = '0;
        sprite_c  = '0;
        frame_sel = '0;
        rst       = 1'b1;

        // Reset values, then release with vsync high.
        cyc("reset", 5, 5, 1'b1, 1'b0, 1'b0);
        cyc("reset", 6, 6, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("release", 7, 7, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Hit window at (300,300), 32x32, solid ROM colour.
        sprite_en = 1'b1;
        sprite_r  = 10'd300;
        sprite_c  = 10'd300;
        vsync_pulse();
        foreach (rows_hit[i]) scan("window", rows_hit[i], 298, 333);

        // Mid-line reset: outputs snap to reset, sprite hidden until next frame.
        for (int hh = 295; hh <= 306; hh++) begin
            rst = (hh == 299 || hh == 300);
            cyc("mid_rst", 310, hh, 1'b1, 1'b0, 1'b1);
        end
        rst = 1'b0;
        scan("hidden", 310, 307, 312);

        // Scaled addressing in frame 2 with a keyed texel.
        for (int i = 512; i < 768; i++) rom_mem[i] = 12'($urandom_range(0, 4095));
        rom_mem[512] = KEY;
        frame_sel = 2'd2;
        vsync_pulse();
        cyc("addr", 305, 310, 1'b1, 1'b1, 1'b1);
        check("addr_225", 12'(rom_addr), 12'h225);
        scan("transparent", 300, 298, 305);
        for (int hh = 300; hh < 304; hh++) cyc("blank", 300, hh, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Tear-free latch: move the sprite mid-frame.
        frame_sel = 2'd0;
        sprite_r  = 10'd300;
        vsync_pulse();
        scan("line100", 100, 299, 301);
        sprite_r = 10'd310;
        for (int vv = 299; vv <= 312; vv++) scan("old_pos", vv, 299, 301);
        vsync_pulse();
        for (int vv = 299; vv <= 312; vv++) scan("new_pos", vv, 299, 301);
        for (int vv = 340; vv <= 342; vv++) scan("new_pos", vv, 299, 301);

        // Clipping at the bottom-right corner.
        sprite_r = 10'd470;
        sprite_c = 10'd620;
        vsync_pulse();
        scan("clip_r0", 0, 0, 2);
        scan("clip_r0", 0, 617, 639);
        scan("clip_469", 469, 617, 639);
        scan("clip_470", 470, 0, 2);
        scan("clip_470", 470, 617, 639);
        scan("clip_479", 479, 617, 639);
        idle(3);

        // Random traffic with random ROM contents, frame starts and resets.
        for (int i = 0; i < 1024; i++)
            rom_mem[i] = ($urandom_range(0, 5) == 0) ? KEY : 12'($urandom_range(0, 4095));
        vs_left    = 0;
        just_reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                sprite_en = 1'($urandom_range(0, 3) != 0);
                sprite_r  = 10'($urandom_range(0, 479));
                sprite_c  = 10'($urandom_range(0, 639));
                frame_sel = 2'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            if (!just_reset && vs_left == 0 && $urandom_range(0, 79) == 0) vs_left = 2;
            vs = (vs_left == 0) || just_reset;
            if (vs_left > 0) vs_left--;
            v = (int'(sprite_r) + $urandom_range(0, 40) - 4) & 1023;
            h = (int'(sprite_c) + $urandom_range(0, 40) - 4) & 1023;
            cyc("random", v, h, 1'($urandom_range(0, 7) != 0), 1'($urandom), vs);
            just_reset = rst;
        end
        rst = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
